riscv_rand_instr_gen: RTL and testbench

//  Synthesizable, parametrised random RV32I instruction source that feeds the core imem response port in sodor verif harnesses.

---
 rtl/rand_instr_pkg.sv | 29 ++
 rtl/riscv_rand_instr_gen_lfsr.sv | 29 ++
 rtl/riscv_rand_instr_gen.sv | 170 +++++++++++++++++
 tb/tb_riscv_rand_instr_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rand_instr_pkg.sv
// Shared types and constants for the random RV32I instruction source.
package rand_instr_pkg;

  typedef enum logic [1:0] {
    KIND_NOP   = 2'd0,
    KIND_RTYPE = 2'd1,
    KIND_ITYPE = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    IDLE,
    NOP,
    RUN,
    DONE
  } state_e;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] word;
  } instr_t;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;
  localparam logic [63:0] LFSR_MASK  = 64'hD800_0000_0000_0000;

  localparam instr_t NOP_INSTR = '{kind: KIND_NOP, word: INSTR_NOP};

endpackage

// File: rtl/riscv_rand_instr_gen_lfsr.sv
// 64-bit right-shifting Galois LFSR; advances one step when advance_i is high.
module rand_lfsr64
  import rand_instr_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h0000_0000_0001_17E4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        advance_i,
  output logic [63:0] state_o
);

  // An all-zero state would lock the register up.
  localparam logic [63:0] SEED_NZ = (SEED == 64'd0) ? 64'd1 : SEED;

  logic [63:0] state_q, state_d;

  assign state_d = advance_i
                 ? ({1'b0, state_q[63:1]} ^ (state_q[0] ? LFSR_MASK : 64'd0))
                 : state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEED_NZ;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/riscv_rand_instr_gen.sv
// Random RV32I R/I-type ALU instruction source with NOP preamble and valid/ready output.
// Optional RAW hazard injection enabled by defining RAND_INSTR_HAZARD_EN.
module riscv_rand_instr_gen
  import rand_instr_pkg::*;
#(
  parameter logic [63:0] SEED       = 64'h0000_0000_0001_17E4,
  parameter int unsigned NUM_INSTR  = 100,
  parameter int unsigned NOP_CYCLES = 3,
  parameter int unsigned ITYPE_WT   = 8,
  parameter logic [4:0]  REG_MASK   = 5'h1F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [1:0]  instr_kind,
  output logic [15:0] instr_count,
  output logic        done
);

  localparam int NOP_W = (NOP_CYCLES < 1) ? 1 : $clog2(NOP_CYCLES + 1);

  state_e             state_q, state_d;
  logic               valid_q, valid_d;
  instr_t             out_q, out_d;
  logic [15:0]        count_q, count_d;
  logic [NOP_W-1:0]   nop_cnt_q, nop_cnt_d;
  logic               load_rand;
  logic [63:0]        lfsr_q;

  rand_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .advance_i (load_rand),
    .state_o   (lfsr_q)
  );

  // Field extraction and legalisation of the word the current LFSR state encodes.
  logic [4:0]  rd_f, rs2_f, rs1_lfsr, rs1_f;
  logic [2:0]  f3_f;
  logic [11:0] imm_raw, imm_f;
  logic [6:0]  funct7_f;
  logic        alt_f, is_itype;
  instr_t      rand_word;
  logic        unused_lfsr;

  assign rd_f     = lfsr_q[4:0]   & REG_MASK;
  assign rs1_lfsr = lfsr_q[9:5]   & REG_MASK;
  assign rs2_f    = lfsr_q[14:10] & REG_MASK;
  assign f3_f     = lfsr_q[17:15];
  assign alt_f    = lfsr_q[40];
  assign imm_raw  = lfsr_q[59:48];
  assign is_itype = 32'(lfsr_q[63:60]) < ITYPE_WT;
  assign unused_lfsr = ^{lfsr_q[47:41], lfsr_q[39:18]};

`ifdef RAND_INSTR_HAZARD_EN
  logic [4:0] prev_rd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             prev_rd_q <= 5'd0;
    else if (load_rand)       prev_rd_q <= rd_f;
    else if (state_q == NOP)  prev_rd_q <= 5'd0;
  end

  assign rs1_f = (alt_f && prev_rd_q != 5'd0) ? prev_rd_q : rs1_lfsr;
`else
  assign rs1_f = rs1_lfsr;
`endif

  // Shift immediates may only carry shamt (plus bit 10 selecting SRAI).
  always_comb begin
    imm_f = imm_raw;
    if (f3_f == 3'd1)      imm_f = imm_raw & 12'h01F;
    else if (f3_f == 3'd5) imm_f = imm_raw & 12'h41F;
  end

  assign funct7_f = (alt_f && (f3_f == 3'd0 || f3_f == 3'd5)) ? 7'h20 : 7'h00;

  assign rand_word = is_itype
    ? instr_t'{kind: KIND_ITYPE, word: {imm_f, rs1_f, f3_f, rd_f, OPC_OP_IMM}}
    : instr_t'{kind: KIND_RTYPE, word: {funct7_f, rs2_f, rs1_f, f3_f, rd_f, OPC_OP}};

  logic xfer, last_nop, last_rand;

  assign xfer      = valid_q & instr_ready;
  assign last_nop  = (32'(nop_cnt_q) + 32'd1) == NOP_CYCLES;
  assign last_rand = (NUM_INSTR != 0) && ((32'(count_q) + 32'd1) == NUM_INSTR);

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    out_d     = out_q;
    count_d   = count_q;
    nop_cnt_d = nop_cnt_q;
    load_rand = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          valid_d = 1'b1;
          if (NOP_CYCLES == 0) begin
            state_d   = RUN;
            load_rand = 1'b1;
          end else begin
            state_d   = NOP;
            out_d     = NOP_INSTR;
            nop_cnt_d = '0;
          end
        end
      end
      NOP: begin
        if (xfer) begin
          nop_cnt_d = nop_cnt_q + NOP_W'(1);
          valid_d   = 1'b0;
          if (last_nop) state_d = RUN;
        end
        if (en && (!valid_q || xfer)) begin
          valid_d = 1'b1;
          if (state_d == RUN) load_rand = 1'b1;
          else                out_d     = NOP_INSTR;
        end
      end
      RUN: begin
        if (xfer) begin
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          valid_d = 1'b0;
          if (last_rand) begin
            state_d = DONE;
            valid_d = 1'b1;
            out_d   = NOP_INSTR;
          end
        end
        if (state_d == RUN && en && (!valid_q || xfer)) begin
          valid_d   = 1'b1;
          load_rand = 1'b1;
        end
      end
      DONE: begin
        valid_d = 1'b1;
        out_d   = NOP_INSTR;
      end
      default: state_d = IDLE;
    endcase
    if (load_rand) out_d = rand_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      out_q     <= NOP_INSTR;
      count_q   <= 16'd0;
      nop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      out_q     <= out_d;
      count_q   <= count_d;
      nop_cnt_q <= nop_cnt_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = out_q.word;
  assign instr_kind  = out_q.kind;
  assign instr_count = count_q;
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_riscv_rand_instr_gen.sv
// Bench for riscv_rand_instr_gen: four configurations share one stimulus stream; each is
// compared against an ordered model of the accepted instruction sequence.
module tb_riscv_rand_instr_gen;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        instr_ready = 1'b0;
  logic        v   [N];
  logic [31:0] ins [N];
  logic [1:0]  kd  [N];
  logic [15:0] cnt [N];
  logic        dn  [N];

  always #5 clk = ~clk;

  riscv_rand_instr_gen #(.SEED(64'h0000_0000_0001_17E4), .NUM_INSTR(100), .NOP_CYCLES(3),
                         .ITYPE_WT(8), .REG_MASK(5'h1F)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .instr_ready(instr_ready),
    .instr_valid(v[0]), .instr(ins[0]), .instr_kind(kd[0]), .instr_count(cnt[0]), .done(dn[0]));

  riscv_rand_instr_gen #(.SEED(64'h0000_0000_0001_17E4), .NUM_INSTR(5), .NOP_CYCLES(3),
                         .ITYPE_WT(8), .REG_MASK(5'h1F)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .instr_ready(instr_ready),
    .instr_valid(v[1]), .instr(ins[1]), .instr_kind(kd[1]), .instr_count(cnt[1]), .done(dn[1]));

  riscv_rand_instr_gen #(.SEED(64'hDEAD_BEEF_0123_4567), .NUM_INSTR(0), .NOP_CYCLES(0),
                         .ITYPE_WT(16), .REG_MASK(5'h1F)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .instr_ready(instr_ready),
    .instr_valid(v[2]), .instr(ins[2]), .instr_kind(kd[2]), .instr_count(cnt[2]), .done(dn[2]));

  riscv_rand_instr_gen #(.SEED(64'h0), .NUM_INSTR(0), .NOP_CYCLES(2),
                         .ITYPE_WT(0), .REG_MASK(5'h07)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .instr_ready(instr_ready),
    .instr_valid(v[3]), .instr(ins[3]), .instr_kind(kd[3]), .instr_count(cnt[3]), .done(dn[3]));

  // Per-instance configuration mirrored from the instantiations above.
  logic [63:0] m_seed [N];
  int          m_num  [N];
  int          m_nop  [N];
  int          m_wt   [N];
  longint      m_msk  [N];

  // Reference model: position in the accepted-word sequence.
  logic [63:0] m_lfsr  [N];
  int          m_xfers [N];
  int          m_rand  [N];
`ifdef RAND_INSTR_HAZARD_EN
  longint      m_prev  [N];
`endif

  logic        pend [N];
  logic [31:0] pins [N];
  logic [1:0]  pkd  [N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'd0);
  endfunction

  // Builds the instruction from LFSR fields by weighted sums of the RV32I field positions.
  function automatic logic [33:0] ref_encode(input int i);
    logic [63:0] s;
    longint sel, imm, alt, f3, rs1, rs2, rd, f7, w;
    logic [1:0] k;
    s   = m_lfsr[i];
    sel = longint'(s[63:60]);
    imm = longint'(s[59:48]);
    alt = longint'(s[40]);
    f3  = longint'(s[17:15]);
    rs2 = longint'(s[14:10]) & m_msk[i];
    rs1 = longint'(s[9:5])   & m_msk[i];
    rd  = longint'(s[4:0])   & m_msk[i];
`ifdef RAND_INSTR_HAZARD_EN
    if (alt == 1 && m_prev[i] != 0) rs1 = m_prev[i];
`endif
    if (sel < m_wt[i]) begin
      if (f3 == 1)      imm = imm % 32;
      else if (f3 == 5) imm = (imm % 32) + ((imm / 1024) % 2) * 1024;
      w = imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19;
      k = 2'd2;
    end else begin
      f7 = ((f3 == 0 || f3 == 5) && alt == 1) ? 32 : 0;
      w = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51;
      k = 2'd1;
    end
    return {k, 32'(w)};
  endfunction

  function automatic logic m_done(input int i);
    return (m_num[i] != 0) && (m_rand[i] >= m_num[i]);
  endfunction

  function automatic logic [33:0] exp_next(input int i);
    if (m_xfers[i] < m_nop[i] || m_done(i)) return {2'd0, 32'h0000_0013};
    return ref_encode(i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_lfsr[i]  = (m_seed[i] == 64'd0) ? 64'd1 : m_seed[i];
      m_xfers[i] = 0;
      m_rand[i]  = 0;
`ifdef RAND_INSTR_HAZARD_EN
      m_prev[i]  = 0;
`endif
      pend[i]    = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s inst%0d valid", tag, i), v[i], 0);
      chk($sformatf("%s inst%0d instr", tag, i), ins[i], 32'h13);
      chk($sformatf("%s inst%0d kind", tag, i), kd[i], 0);
      chk($sformatf("%s inst%0d count", tag, i), cnt[i], 0);
      chk($sformatf("%s inst%0d done", tag, i), dn[i], 0);
    end
  endtask

  // Called at posedge+1; drives ready for the coming edge, checks, then advances one cycle.
  task automatic step(input logic rdy);
    logic [33:0] e;
    instr_ready = rdy;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("inst%0d count", i), cnt[i], m_rand[i]);
      chk($sformatf("inst%0d done", i), dn[i], m_done(i));
      if (m_done(i)) chk($sformatf("inst%0d done valid", i), v[i], 1);
      if (pend[i]) begin
        chk($sformatf("inst%0d stall valid", i), v[i], 1);
        chk($sformatf("inst%0d stall instr", i), ins[i], pins[i]);
        chk($sformatf("inst%0d stall kind", i), kd[i], pkd[i]);
      end
      if (v[i] && rdy) begin
        e = exp_next(i);
        chk($sformatf("inst%0d instr #%0d", i, m_xfers[i]), ins[i], e[31:0]);
        chk($sformatf("inst%0d kind #%0d", i, m_xfers[i]), kd[i], e[33:32]);
        if (i == 2 && kd[i] != 2'd0) begin
          chk("inst2 opcode", ins[i][6:0], 7'h13);
          if (ins[i][14:12] == 3'd1) chk("inst2 slli imm", ins[i][31:25], 0);
          if (ins[i][14:12] == 3'd5) chk("inst2 srxi imm", ins[i][31:20] & 12'hBE0, 0);
        end
        if (i == 3 && kd[i] != 2'd0) begin
          chk("inst3 opcode", ins[i][6:0], 7'h33);
          chk("inst3 reg range", (ins[i][11:7] <= 7) && (ins[i][19:15] <= 7) && (ins[i][24:20] <= 7), 1);
          chk("inst3 funct7", (ins[i][31:25] == 7'h00) ||
              (ins[i][31:25] == 7'h20 && (ins[i][14:12] == 3'd0 || ins[i][14:12] == 3'd5)), 1);
        end
        if (e[33:32] != 2'd0) begin
          m_rand[i]++;
`ifdef RAND_INSTR_HAZARD_EN
          m_prev[i] = longint'(e[11:7]);
`endif
          m_lfsr[i] = lfsr_step(m_lfsr[i]);
        end
        m_xfers[i]++;
      end
      pend[i] = v[i] && !rdy;
      pins[i] = ins[i];
      pkd[i]  = kd[i];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_seed = '{64'h0000_0000_0001_17E4, 64'h0000_0000_0001_17E4, 64'hDEAD_BEEF_0123_4567, 64'h0};
    m_num  = '{100, 5, 0, 0};
    m_nop  = '{3, 3, 0, 2};
    m_wt   = '{8, 8, 16, 0};
    m_msk  = '{31, 31, 31, 7};
    model_reset();

    #12;
    chk_reset("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("idle");

    // Valid must appear exactly one cycle after en is sampled.
    en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("inst%0d first valid", i), v[i], 1);
    for (int c = 0; c < 20; c++) step(1'b1);

    // Consumer stall mid-stream.
    for (int c = 0; c < 4; c++) step(1'b0);
    for (int c = 0; c < 3; c++) step(1'b1);

    // en low: pending word drains, then nothing new is offered.
    en = 1'b0;
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < N; i++) chk($sformatf("inst%0d en-low valid", i), v[i], dn[i]);
    step(1'b0);
    step(1'b1);
    en = 1'b1;
    for (int c = 0; c < 30; c++) step($urandom_range(0, 3) != 0);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("async");
    model_reset();
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("inst%0d restart valid", i), v[i], 1);

    for (int c = 0; c < 1600; c++) begin
      en = ($urandom_range(0, 15) != 0);
      step($urandom_range(0, 3) != 0);
    end
    en = 1'b1;
    for (int c = 0; c < 200; c++) step(1'b1);
    chk("inst2 volume", cnt[2] >= 16'd1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
